// File: rtl/quarter_sine_interp_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : quarter_sine_interp_mc                                     |
// | Description : Four-stage pipelined sine generator. A phase word plus a   |
// |               quarter-turn mode offset addresses a mirrored quarter-wave |
// |               ROM; two neighbouring entries are linearly interpolated    |
// |               on the fractional phase bits.                              |
// | Ports       : clk, rst (sync, active-high), clk_en (pipeline advance)    |
// |               i_valid/i_phase/i_mode/i_midi/i_ch : per-sample inputs     |
// |               o_valid/o_sine/o_midi/o_ch         : 4 enabled cycles later|
// | Config      : QSINE_ROUND_EN - round half up with positive saturation    |
// |               instead of plain truncation of the dropped low bits.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module quarter_sine_interp_mc #(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 9,
    parameter int LUT_DW  = 16,
    parameter int OUT_W   = 24,
    parameter int CH_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    i_valid,
    input  logic [PHASE_W-1:0]      i_phase,
    input  logic [1:0]              i_mode,
    input  logic [6:0]              i_midi,
    input  logic [CH_W-1:0]         i_ch,
    output logic                    o_valid,
    output logic signed [OUT_W-1:0] o_sine,
    output logic [6:0]              o_midi,
    output logic [CH_W-1:0]         o_ch
);

    localparam int c_f     = PHASE_W - 2 - LUT_AW;   // fractional phase bits
    localparam int c_qw    = LUT_AW + 2;             // quadrant + address bits
    localparam int c_sum_w = LUT_DW + c_f + 1;
    localparam int c_d     = LUT_DW + c_f - OUT_W;   // dropped low bits
    localparam int c_depth = 1 << LUT_AW;
    localparam logic signed [OUT_W-1:0] c_out_max = {1'b0, {(OUT_W-1){1'b1}}};

    // Quarter-wave entry k, sampled at the half-step (k+0.5) so that the
    // mirrored quadrants land on exactly the same set of values. A Taylor
    // series keeps the elaboration-time evaluation to plain real arithmetic.
    function automatic logic [LUT_DW-1:0] lut_entry(input int k);
        real x;
        real term;
        real acc;
        real amp;
        x    = (3.14159265358979323846 / 2.0) * (real'(k) + 0.5) / real'(c_depth);
        term = x;
        acc  = x;
        for (int n = 1; n < 14; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        amp = real'((1 << (LUT_DW - 1)) - 1);
        return LUT_DW'($rtoi(amp * acc + 0.5));
    endfunction

    logic signed [LUT_DW-1:0] w_lut [c_depth];

    for (genvar k = 0; k < c_depth; k++) begin : g_lut
        localparam logic [LUT_DW-1:0] c_val = lut_entry(k);
        assign w_lut[k] = c_val;
    end

    // ---------------- S1: phase offset and address split -----------------
    logic [PHASE_W-1:0] w_p;
    logic [c_qw-1:0]    w_q;
    logic [c_qw-1:0]    w_qn;

    assign w_p  = i_phase + {i_mode, {(PHASE_W-2){1'b0}}};
    assign w_q  = w_p[PHASE_W-1 -: c_qw];
    assign w_qn = w_q + c_qw'(1);   // wraps to 0 at the end of the turn

    logic              r_neg0_1, r_neg1_1;
    logic [LUT_AW-1:0] r_addr0_1, r_addr1_1;
    logic [c_f-1:0]    r_frac_1;

    // ---------------- S2: ROM read ----------------------------------------
    logic signed [LUT_DW-1:0] r_l0_2, r_l1_2;
    logic                     r_neg0_2, r_neg1_2;
    logic [c_f-1:0]           r_frac_2;

    // ---------------- S3: sign and weights --------------------------------
    logic signed [LUT_DW-1:0] r_a0_3, r_a1_3;
    logic [c_f:0]             r_w0_3;
    logic [c_f-1:0]           r_w1_3;

    always_ff @(posedge clk) begin
        if (clk_en) begin
            r_neg0_1  <= w_q[c_qw-1];
            r_neg1_1  <= w_qn[c_qw-1];
            // Odd quadrants run the quarter wave backwards.
            r_addr0_1 <= w_q[LUT_AW]  ? ~w_q[LUT_AW-1:0]  : w_q[LUT_AW-1:0];
            r_addr1_1 <= w_qn[LUT_AW] ? ~w_qn[LUT_AW-1:0] : w_qn[LUT_AW-1:0];
            r_frac_1  <= w_p[c_f-1:0];

            r_l0_2    <= w_lut[r_addr0_1];
            r_l1_2    <= w_lut[r_addr1_1];
            r_neg0_2  <= r_neg0_1;
            r_neg1_2  <= r_neg1_1;
            r_frac_2  <= r_frac_1;

            // ROM entries are never negative, so negation cannot overflow.
            r_a0_3    <= r_neg0_2 ? -r_l0_2 : r_l0_2;
            r_a1_3    <= r_neg1_2 ? -r_l1_2 : r_l1_2;
            r_w0_3    <= {1'b1, {c_f{1'b0}}} - {1'b0, r_frac_2};
            r_w1_3    <= r_frac_2;
        end
    end

    // ---------------- S4: interpolate and scale ---------------------------
    logic [c_sum_w-1:0]      w_a0x, w_a1x, w_w0x, w_w1x, w_sum;
    logic signed [OUT_W-1:0] w_out;
    logic                    w_unused;

    // Everything is widened to the sum width first; the products are then
    // exact modulo 2^c_sum_w, which is all the two's-complement sum needs.
    assign w_a0x = {{(c_sum_w-LUT_DW){r_a0_3[LUT_DW-1]}}, r_a0_3};
    assign w_a1x = {{(c_sum_w-LUT_DW){r_a1_3[LUT_DW-1]}}, r_a1_3};
    assign w_w0x = {{(c_sum_w-c_f-1){1'b0}}, r_w0_3};
    assign w_w1x = {{(c_sum_w-c_f){1'b0}}, r_w1_3};
    assign w_sum = w_a0x * w_w0x + w_a1x * w_w1x;

`ifdef QSINE_ROUND_EN
    logic [c_sum_w:0] w_rnd;
    logic             w_ovf;

    if (c_d > 0) begin : g_rnd_add
        assign w_rnd = {w_sum[c_sum_w-1], w_sum} + ((c_sum_w+1)'(1) << (c_d - 1));
    end else begin : g_rnd_pass
        assign w_rnd = {w_sum[c_sum_w-1], w_sum};
    end

    // Only a non-negative result can run past the top of the output range.
    assign w_ovf    = ~w_rnd[c_sum_w] & (|w_rnd[c_sum_w-1:LUT_DW+c_f-1]);
    assign w_out    = w_ovf ? c_out_max : w_rnd[LUT_DW+c_f-1 -: OUT_W];
    assign w_unused = ^w_rnd;
`else
    assign w_out    = w_sum[LUT_DW+c_f-1 -: OUT_W];
    assign w_unused = ^w_sum;
`endif

    // ---------------- sideband shift register and output ------------------
    logic [3:0]              r_vld;
    logic [6:0]              r_midi [4];
    logic [CH_W-1:0]         r_ch   [4];
    logic signed [OUT_W-1:0] r_sine;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r_sine <= '0;
            for (int i = 0; i < 4; i++) begin
                r_midi[i] <= '0;
                r_ch[i]   <= '0;
            end
        end else if (clk_en) begin
            r_vld     <= {r_vld[2:0], i_valid};
            r_midi[0] <= i_midi;
            r_ch[0]   <= i_ch;
            for (int i = 1; i < 4; i++) begin
                r_midi[i] <= r_midi[i-1];
                r_ch[i]   <= r_ch[i-1];
            end
            r_sine    <= r_vld[2] ? w_out : '0;
        end
    end

    assign o_valid = r_vld[3];
    assign o_sine  = r_sine;
    assign o_midi  = r_midi[3];
    assign o_ch    = r_ch[3];

endmodule
`default_nettype wire

// File: tb/tb_quarter_sine_interp_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_quarter_sine_interp_mc                                  |
// | Description : Directed and random stimulus for quarter_sine_interp_mc,   |
// |               checked against an arithmetic sine/interpolation model.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_quarter_sine_interp_mc;

    localparam int PHASE_W = 24;
    localparam int LUT_AW  = 9;
    localparam int LUT_DW  = 16;
    localparam int OUT_W   = 24;
    localparam int CH_W    = 4;
    localparam int F       = PHASE_W - 2 - LUT_AW;
    localparam int D       = LUT_DW + F - OUT_W;
    localparam int NQ      = 1 << LUT_AW;
    localparam int HIST    = 8192;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clk_en;
    logic                    i_valid;
    logic [PHASE_W-1:0]      i_phase;
    logic [1:0]              i_mode;
    logic [6:0]              i_midi;
    logic [CH_W-1:0]         i_ch;
    logic                    o_valid;
    logic signed [OUT_W-1:0] o_sine;
    logic [6:0]              o_midi;
    logic [CH_W-1:0]         o_ch;

    quarter_sine_interp_mc #(
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .LUT_DW  (LUT_DW),
        .OUT_W   (OUT_W),
        .CH_W    (CH_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .i_valid (i_valid),
        .i_phase (i_phase),
        .i_mode  (i_mode),
        .i_midi  (i_midi),
        .i_ch    (i_ch),
        .o_valid (o_valid),
        .o_sine  (o_sine),
        .o_midi  (o_midi),
        .o_ch    (o_ch)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Quarter-wave table straight from the sine definition.
    int lut [NQ];

    // Every enabled input slot since the last reset, indexed 1..n.
    int n = 0;
    bit h_valid [HIST];
    int h_phase [HIST];
    int h_mode  [HIST];
    int h_midi  [HIST];
    int h_ch    [HIST];

    logic                    e_valid;
    logic signed [OUT_W-1:0] e_sine;
    logic [6:0]              e_midi;
    logic [CH_W-1:0]         e_ch;

    function automatic longint quarter(input longint q);
        longint quad;
        longint k;
        longint v;
        quad = q / NQ;
        k    = q % NQ;
        if (quad % 2 == 1) k = NQ - 1 - k;
        v = lut[int'(k)];
        if (quad >= 2) v = -v;
        return v;
    endfunction

    function automatic int ref_sine(input int ph, input int md);
        longint p, q, qn, fr, s, r;
        p  = (longint'(ph) + longint'(md) * (longint'(1) << (PHASE_W - 2)))
             % (longint'(1) << PHASE_W);
        q  = p >> F;
        fr = p % (longint'(1) << F);
        qn = (q + 1) % (4 * NQ);
        s  = quarter(q) * ((longint'(1) << F) - fr) + quarter(qn) * fr;
`ifdef QSINE_ROUND_EN
        if (D > 0) s = s + (longint'(1) << (D - 1));
        r = s >>> D;
        if (r > (longint'(1) << (OUT_W - 1)) - 1) r = (longint'(1) << (OUT_W - 1)) - 1;
`else
        r = s >>> D;
`endif
        return int'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit r, input bit en, input bit v, input int ph,
                        input int md, input int mi, input int c);
        int k;
        rst     = r;
        clk_en  = en;
        i_valid = v;
        i_phase = PHASE_W'(ph);
        i_mode  = 2'(md);
        i_midi  = 7'(mi);
        i_ch    = CH_W'(c);
        @(posedge clk);
        #1;
        if (r) begin
            n       = 0;
            e_valid = 1'b0;
            e_sine  = '0;
            e_midi  = '0;
            e_ch    = '0;
        end else if (en) begin
            n++;
            h_valid[n] = v;
            h_phase[n] = ph;
            h_mode[n]  = md;
            h_midi[n]  = mi;
            h_ch[n]    = c;
            k = n - 3;
            if (k >= 1) begin
                e_valid = h_valid[k];
                e_sine  = h_valid[k] ? OUT_W'(ref_sine(h_phase[k], h_mode[k])) : '0;
                e_midi  = 7'(h_midi[k]);
                e_ch    = CH_W'(h_ch[k]);
            end else begin
                e_valid = 1'b0;
                e_sine  = '0;
                e_midi  = '0;
                e_ch    = '0;
            end
        end
        check("valid", 32'(o_valid), 32'(e_valid));
        check("sine",  32'(o_sine),  32'(e_sine));
        check("midi",  32'(o_midi),  32'(e_midi));
        check("ch",    32'(o_ch),    32'(e_ch));
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b1, 1'b0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < NQ; k++)
            lut[k] = $rtoi(real'((1 << (LUT_DW - 1)) - 1)
                     * $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / real'(NQ)) + 0.5);

        // Reset state.
        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("rst_valid", 32'(o_valid), 32'(0));
        check("rst_sine",  32'(o_sine),  32'(0));

        // Single sample at phase 0: appears after exactly four enabled edges.
        step(1'b0, 1'b1, 1'b1, 0, 0, 7'h55, 4'hA);
        idle(2);
        check("lat_early", 32'(o_valid), 32'(0));
        idle(1);
        check("ph0_valid", 32'(o_valid), 32'(1));
        check("ph0_sine",  32'(o_sine),  32'(12800));
        check("ph0_midi",  32'(o_midi),  32'(7'h55));
        check("ph0_ch",    32'(o_ch),    32'(4'hA));
        idle(1);
        check("ph0_once",  32'(o_valid), 32'(0));

        // Back-to-back: quarter turn, half turn, nonzero fraction.
        step(1'b0, 1'b1, 1'b1, 32'h400000, 0, 1, 1);
        step(1'b0, 1'b1, 1'b1, 32'h800000, 0, 2, 2);
        step(1'b0, 1'b1, 1'b1, 32'h001000, 0, 3, 3);
        idle(1);
        check("b2b_quarter", 32'(o_sine), 32'(8388352));
        idle(1);
        check("b2b_half",    32'(o_sine), 32'(-12800));
        idle(1);
        check("b2b_frac",    32'(o_sine), 32'(25728));

        // Mode offsets; phase 0x400000 with mode 3 wraps the offset phase to 0.
        step(1'b0, 1'b1, 1'b1, 0,          1, 4, 4);
        step(1'b0, 1'b1, 1'b1, 32'h400000, 3, 5, 5);
        step(1'b0, 1'b1, 1'b1, 32'h400000, 1, 6, 6);
        idle(1);
        check("cos0",       32'(o_sine), 32'(8388352));
        idle(1);
        check("mode3_wrap", 32'(o_sine), 32'(12800));
        idle(1);
        check("cos_quarter", 32'(o_sine), 32'(-12800));

        // Last quantum of the turn interpolates into entry 0 of the next turn.
        step(1'b0, 1'b1, 1'b1, 32'hFFF000, 0, 7, 7);
        idle(3);
        check("wrap_valid", 32'(o_valid), 32'(1));
        check("wrap_sine",  32'(o_sine),  32'(0));

        // Random phases, continuous enable.
        for (int i = 0; i < 200; i++)
            step(1'b0, 1'b1, ($urandom_range(3) != 0), int'($urandom_range(32'hFFFFFF)),
                 int'($urandom_range(3)), int'($urandom_range(127)), int'($urandom_range(15)));

        // Random phases with the enable toggling.
        for (int i = 0; i < 300; i++)
            step(1'b0, ($urandom_range(2) != 0), ($urandom_range(3) != 0),
                 int'($urandom_range(32'hFFFFFF)), int'($urandom_range(3)),
                 int'($urandom_range(127)), int'($urandom_range(15)));

        // Three samples in flight, then reset: none of them may emerge.
        step(1'b0, 1'b1, 1'b1, 32'h123456, 0, 9, 9);
        step(1'b0, 1'b1, 1'b1, 32'h234567, 1, 10, 10);
        step(1'b0, 1'b1, 1'b1, 32'h345678, 2, 11, 11);
        step(1'b1, 1'b1, 1'b0, 0, 0, 0, 0);
        check("flush_valid", 32'(o_valid), 32'(0));
        check("flush_sine",  32'(o_sine),  32'(0));
        idle(6);

        // Reset with the enable low still discards in-flight samples.
        step(1'b0, 1'b1, 1'b1, 32'h456789, 0, 12, 12);
        step(1'b0, 1'b1, 1'b1, 32'h56789A, 0, 13, 13);
        step(1'b0, 1'b1, 1'b1, 32'h6789AB, 0, 14, 14);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        check("flush_noen_valid", 32'(o_valid), 32'(0));
        idle(6);

        // A final random burst after reset with the enable toggling.
        for (int i = 0; i < 100; i++)
            step(1'b0, ($urandom_range(1) != 0), 1'b1, int'($urandom_range(32'hFFFFFF)),
                 int'($urandom_range(3)), int'($urandom_range(127)), int'($urandom_range(15)));
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
